// File: rtl/vscale_fetch_stage.sv
// rtl/vscale_fetch_stage.sv - IF stage: PC_IF register, imem request/response handshake, DX delivery
// Optional: VSCALE_FETCH_PERF_EN adds the fetch_stall_cycles counter output.
module vscale_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] PC_PIF,
    input  logic        kill_IF,
    input  logic        stall_DX,
    input  logic        kill_DX,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] PC_IF,
    output logic [31:0] PC_DX,
    output logic [31:0] inst_DX,
    output logic        inst_valid_DX
`ifdef VSCALE_FETCH_PERF_EN
    ,
    output logic [31:0] fetch_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_if_q, pc_if_d;
    logic [31:0] pc_dx_q, pc_dx_d;
    logic [31:0] inst_dx_q, inst_dx_d;
    logic [31:0] skid_q, skid_d;
    logic        inst_valid_q, inst_valid_d;
    logic        drop_q, drop_d;
    logic        deliver;
    logic [31:0] deliver_data;

    always_comb begin
        state_d        = state_q;
        pc_if_d        = pc_if_q;
        drop_d         = drop_q;
        skid_d         = skid_q;
        deliver        = 1'b0;
        deliver_data   = skid_q;
        imem_req_valid = 1'b0;
        case (state_q)
            S_REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                    if (kill_IF) begin
                        drop_d  = 1'b1;
                        pc_if_d = PC_PIF;
                    end
                end else if (kill_IF) begin
                    pc_if_d = PC_PIF;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                    if (drop_q || kill_IF) begin
                        drop_d = 1'b0;
                        if (kill_IF) pc_if_d = PC_PIF;
                    end else if (!stall_DX) begin
                        deliver      = 1'b1;
                        deliver_data = imem_resp_data;
                        pc_if_d      = PC_PIF;
                    end else begin
                        skid_d  = imem_resp_data;
                        state_d = S_HOLD;
                    end
                end else if (kill_IF) begin
                    drop_d  = 1'b1;
                    pc_if_d = PC_PIF;
                end
            end
            S_HOLD: begin
                if (kill_IF) begin
                    pc_if_d = PC_PIF;
                    state_d = S_REQ;
                end else if (!stall_DX) begin
                    deliver = 1'b1;
                    pc_if_d = PC_PIF;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // A delivery wins over kill_DX; otherwise a free-running DX takes a bubble.
    always_comb begin
        pc_dx_d      = pc_dx_q;
        inst_dx_d    = inst_dx_q;
        inst_valid_d = inst_valid_q;
        if (deliver) begin
            pc_dx_d      = pc_if_q;
            inst_dx_d    = deliver_data;
            inst_valid_d = 1'b1;
        end else if (kill_DX || !stall_DX) begin
            inst_dx_d    = NOP_INST;
            inst_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_REQ;
            pc_if_q      <= RESET_PC;
            pc_dx_q      <= 32'h0;
            inst_dx_q    <= NOP_INST;
            inst_valid_q <= 1'b0;
            skid_q       <= 32'h0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_if_q      <= pc_if_d;
            pc_dx_q      <= pc_dx_d;
            inst_dx_q    <= inst_dx_d;
            inst_valid_q <= inst_valid_d;
            skid_q       <= skid_d;
            drop_q       <= drop_d;
        end
    end

`ifdef VSCALE_FETCH_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!deliver) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_cnt_q <= 32'h0;
        else          stall_cnt_q <= stall_cnt_d;
    end

    assign fetch_stall_cycles = stall_cnt_q;
`endif

    assign imem_req_addr = pc_if_q;
    assign PC_IF         = pc_if_q;
    assign PC_DX         = pc_dx_q;
    assign inst_DX       = inst_dx_q;
    assign inst_valid_DX = inst_valid_q;

endmodule

// File: doc/vscale_fetch_stage.md
Name: vscale_fetch_stage

Overview:
- Consumer end of the next-PC interface: registers the PC_PIF value produced by the PC-select logic into PC_IF.
- Issues one instruction-memory request per PC over a valid/ready handshake and waits for the response.
- Delivers the fetched instruction and its PC into the DX pipeline register.
- Handles stall, kill/redirect and response back-pressure (one-entry skid buffer). Sits between the PC-select logic, imem and the DX stage.

Parameters:
- RESET_PC, 32'h200: PC_IF value at reset; the first fetch address.
- NOP_INST, 32'h00000013: instruction placed in inst_DX on a bubble (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- PC_PIF  in  32  next PC (combinational; PC_IF+4 by default, redirect target when kill_IF).
- kill_IF  in  1  redirect: squash the IF fetch and load PC_IF from PC_PIF.
- stall_DX  in  1  DX holds its contents; no delivery.
- kill_DX  in  1  forces a bubble into DX when no delivery occurs.
- imem_req_valid  out  1  request valid.
- imem_req_addr  out  32  request address (= PC_IF).
- imem_req_ready  in  1  memory accepts the request.
- imem_resp_valid  in  1  response data valid (exactly one per accepted request).
- imem_resp_data  in  32  fetched instruction.
- PC_IF  out  32  PC of the instruction currently being fetched.
- PC_DX  out  32  PC of the instruction in DX.
- inst_DX  out  32  instruction in DX.
- inst_valid_DX  out  1  inst_DX is a real instruction.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State REQ; PC_IF=RESET_PC; PC_DX=0; inst_DX=NOP_INST; inst_valid_DX=0.
  - drop flag=0; skid buffer empty.
  - Reset mid-transaction abandons the outstanding request. The memory side must also be reset, because a late response is ignored only while the block is in REQ.
- At most one outstanding request. imem_req_addr=PC_IF at all times.
- FSM states: REQ, WAIT, HOLD.
- REQ:
  - imem_req_valid=1.
  - If ready: go to WAIT. If kill_IF is also asserted that cycle, set drop=1 and PC_IF<=PC_PIF.
  - If not ready and kill_IF: PC_IF<=PC_PIF; stay in REQ (the new address is presented next cycle).
- WAIT:
  - imem_req_valid=0.
  - kill_IF without response: drop<=1; PC_IF<=PC_PIF.
  - Response with (drop=1 or kill_IF): discard it; drop<=0; PC_IF<=PC_PIF if kill_IF; go to REQ.
  - Response, no drop, !stall_DX: deliver; PC_IF<=PC_PIF; go to REQ.
  - Response, no drop, stall_DX: capture data into the skid buffer; go to HOLD.
- HOLD:
  - imem_req_valid=0.
  - kill_IF: discard buffer; PC_IF<=PC_PIF; go to REQ.
  - Else if !stall_DX: deliver from buffer; PC_IF<=PC_PIF; go to REQ.
- Deliver: inst_DX<=data, PC_DX<=PC_IF, inst_valid_DX<=1.
- DX register priority per cycle:
  1. deliver;
  2. else kill_DX or !stall_DX: bubble (inst_DX<=NOP_INST, inst_valid_DX<=0, PC_DX unchanged);
  3. else hold.
- Throughput: with a zero-wait memory (ready=1, response the cycle after accept), one instruction every 2 cycles. Latency from request accept to inst_valid_DX is 2 edges.
- PC arithmetic is done entirely upstream. PC_IF wraps naturally at 32 bits; no alignment check.

Optional Feature:
- Macro VSCALE_FETCH_PERF_EN.
- Defined: adds output fetch_stall_cycles [31:0], reset 0. It increments by 1 on every clock edge where the block is not in reset and no delivery occurs. It wraps from 32'hFFFFFFFF to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, ready=1, 1-cycle response 0x00100093, PC_PIF=PC_IF+4 → imem_req_addr=0x200; inst_DX=0x00100093, PC_DX=0x200, valid=1; then imem_req_addr=0x204.
- Response arrives with stall_DX=1 for 3 cycles → HOLD, inst_DX unchanged; on release inst_DX=buffered data, PC_DX=0x204, no new request until then.
- kill_IF with PC_PIF=0x400 while in WAIT; response comes 2 cycles later → response discarded, inst_valid_DX stays 0, next request addr=0x400.
- kill_IF in the same cycle as the REQ handshake at 0x208, PC_PIF=0x300 → 0x208 response dropped; next request 0x300.
- ready=0 for 5 cycles → imem_req_valid held at 1 with a stable address; DX bubbles (inst_DX=0x13, valid=0).
- With VSCALE_FETCH_PERF_EN: the ready=0 scenario above → fetch_stall_cycles increases by 5 over those cycles; reset_n pulse mid-count → 0.
